// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: responder FSM states and address-map constants.
// The vector window (VEC_LO..VEC_HI) keeps its full 24-bit address even in
// 16-bit addressing mode. AB16_BANK is the bank forced onto 16-bit accesses.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    REQ,
    DONE
  } state_t;

  localparam logic [23:0] VEC_LO    = 24'hFFFFF7;
  localparam logic [23:0] VEC_HI    = 24'hFFFFFF;
  localparam logic [7:0]  AB16_BANK = 8'h00;

  // Shared wait/timeout counter width
  localparam int unsigned CNT_W = 6;

endpackage

// File: rtl/bus_addr_map.sv
// Combinational effective-address and region decode for the CPU bus.
// Ports:
//   ab      in  24  raw CPU address
//   abwdth  in  1   1 = 24-bit addressing, 0 = 16-bit (bank forced)
//   ea      out 24  effective address
//   is_rom  out 1   effective address falls in the ROM bank
module bus_addr_map
  import cpu_bus_pkg::*;
#(
  parameter logic [7:0] ROM_BANK = 8'hFF
) (
  input  logic [23:0] ab,
  input  logic        abwdth,
  output logic [23:0] ea,
  output logic        is_rom
);

  logic [23:0] vec_off;
  logic        is_vec;

  always_comb begin
    // Offset compare keeps the window check correct even when VEC_HI is the
    // top of the address space.
    vec_off = ab - VEC_LO;
    is_vec  = (vec_off <= (VEC_HI - VEC_LO));
    if (abwdth || is_vec) begin
      ea = ab;
    end else begin
      ea = {AB16_BANK, ab[15:0]};
    end
    is_rom = (ea[23:16] == ROM_BANK);
  end

endmodule

// File: rtl/bus_responder.sv
// CPU-side memory responder. Latches each CPU access, optionally inserts ROM
// wait cycles, runs one req/ack handshake on the external port, and returns
// read data on DI with RDY as the CPU stall.
// Ports:
//   clk        in  1   clock, rising edge
//   RST_N      in  1   async active-low reset
//   AB         in  24  CPU address
//   WE         in  1   CPU write strobe
//   DO         in  8   CPU write data
//   ABWDTH     in  1   1 = 24-bit addressing, 0 = 16-bit
//   DI         out 8   read data to CPU
//   RDY        out 1   access complete / CPU may advance
//   mem_req    out 1   external request, held until mem_ack
//   mem_we     out 1   external write qualifier
//   mem_addr   out 24  effective address
//   mem_wdata  out 8   external write data
//   mem_rdata  in  8   external read data
//   mem_ack    in  1   one-cycle completion pulse
//   bus_err    out 1   sticky timeout flag
module bus_responder
  import cpu_bus_pkg::*;
#(
  parameter logic [7:0]  ROM_BANK = 8'hFF,
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned ACK_TMO  = 63
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [23:0] AB,
  input  logic        WE,
  input  logic [7:0]  DO,
  input  logic        ABWDTH,
  output logic [7:0]  DI,
  output logic        RDY,
  output logic        mem_req,
  output logic        mem_we,
  output logic [23:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [23:0]      ea;
  logic             is_rom;
  logic             latch;
  logic             take_ack;
  logic             tmo;

  bus_addr_map #(
    .ROM_BANK (ROM_BANK)
  ) u_map (
    .ab     (AB),
    .abwdth (ABWDTH),
    .ea     (ea),
    .is_rom (is_rom)
  );

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    latch    = 1'b0;
    take_ack = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: begin
        // RDY=0 only on the first cycle after reset; no access is taken then.
        if (RDY) begin
          latch = 1'b1;
          if (is_rom && WE) begin
            state_n = DONE;
          end else if (is_rom && (ROM_WAIT != 0)) begin
            state_n = WAIT;
            cnt_n   = CNT_W'(ROM_WAIT - 1);
          end else begin
            state_n = REQ;
            cnt_n   = '0;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_n = REQ;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      REQ: begin
        // Counter now counts REQ cycles without an ack.
        if (mem_ack) begin
          take_ack = 1'b1;
          state_n  = DONE;
        end else if (cnt == CNT_W'(ACK_TMO - 1)) begin
          tmo     = 1'b1;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      RDY       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      DI        <= '0;
      bus_err   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      RDY     <= (state_n == IDLE) || (state_n == DONE);
      mem_req <= (state_n == REQ);
      if (latch) begin
        mem_addr  <= ea;
        mem_we    <= WE;
        mem_wdata <= DO;
      end
      if (take_ack && !mem_we) begin
        DI <= mem_rdata;
      end
      if (tmo) begin
        bus_err <= 1'b1;
        DI      <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder.
module tb_bus_responder;

  logic        clk;
  logic        RST_N;
  logic [23:0] AB;
  logic        WE;
  logic [7:0]  DO;
  logic        ABWDTH;
  logic [7:0]  DI;
  logic        RDY;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        bus_err;

  int n_cmp;
  int n_bad;

  bus_responder #(
    .ROM_BANK (8'hFF),
    .ROM_WAIT (2),
    .ACK_TMO  (63)
  ) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .AB        (AB),
    .WE        (WE),
    .DO        (DO),
    .ABWDTH    (ABWDTH),
    .DI        (DI),
    .RDY       (RDY),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    RST_N     = 1'b0;
    AB        = '0;
    WE        = 1'b0;
    DO        = '0;
    ABWDTH    = 1'b1;
    mem_rdata = '0;
    mem_ack   = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_rdy", 32'(RDY), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_di", 32'(DI), 32'h00);
    chk("rst_err", 32'(bus_err), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    RST_N = 1'b1;
    chk("rel_rdy0", 32'(RDY), 32'h0);
    tick();
    chk("rel_rdy1", 32'(RDY), 32'h1);

    // 1: RAM read, ack one cycle after req
    AB = 24'h012345; WE = 1'b0; ABWDTH = 1'b1;
    tick();
    chk("t1_req", 32'(mem_req), 32'h1);
    chk("t1_addr", 32'(mem_addr), 32'h012345);
    chk("t1_rdy0", 32'(RDY), 32'h0);
    tick();
    chk("t1_hold", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 8'hA5;
    tick();
    mem_ack = 1'b0;
    chk("t1_rdy1", 32'(RDY), 32'h1);
    chk("t1_reqdrop", 32'(mem_req), 32'h0);
    chk("t1_di", 32'(DI), 32'hA5);
    tick();

    // 2a: 16-bit addressing forces bank 00; same-cycle ack
    AB = 24'h7F1234; ABWDTH = 1'b0;
    tick();
    chk("t2_addr16", 32'(mem_addr), 32'h001234);
    chk("t2_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_ack = 1'b0;
    chk("t2_di", 32'(DI), 32'h5A);
    chk("t2_rdy", 32'(RDY), 32'h1);
    tick();

    // 2b: vector window keeps full address (lands in ROM bank -> wait path)
    AB = 24'hFFFFFA;
    tick();
    chk("t2_vec_addr", 32'(mem_addr), 32'hFFFFFA);
    chk("t2_vec_wait", 32'(mem_req), 32'h0);
    tick();
    tick();
    chk("t2_vec_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    chk("t2_vec_di", 32'(DI), 32'h77);
    tick();

    // 3: ROM read with two wait cycles, then ROM write dropped
    AB = 24'hFF8000; ABWDTH = 1'b1; WE = 1'b0;
    tick();
    chk("t3_w1_req", 32'(mem_req), 32'h0);
    chk("t3_w1_rdy", 32'(RDY), 32'h0);
    tick();
    chk("t3_w2_req", 32'(mem_req), 32'h0);
    tick();
    chk("t3_req", 32'(mem_req), 32'h1);
    chk("t3_addr", 32'(mem_addr), 32'hFF8000);
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    tick();
    mem_ack = 1'b0;
    chk("t3_di", 32'(DI), 32'hC3);
    tick();
    WE = 1'b1; DO = 8'h11;
    tick();
    chk("t3_wr_rdy", 32'(RDY), 32'h1);
    chk("t3_wr_noreq", 32'(mem_req), 32'h0);
    tick();
    chk("t3_wr_noreq2", 32'(mem_req), 32'h0);

    // 4: RAM write holds we/wdata until ack, DI untouched
    AB = 24'h000200; WE = 1'b1; DO = 8'h3C;
    tick();
    chk("t4_req", 32'(mem_req), 32'h1);
    chk("t4_we", 32'(mem_we), 32'h1);
    chk("t4_wdata", 32'(mem_wdata), 32'h3C);
    tick();
    chk("t4_hold_we", 32'(mem_we), 32'h1);
    chk("t4_hold_wd", 32'(mem_wdata), 32'h3C);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    tick();
    mem_ack = 1'b0;
    WE = 1'b0;
    chk("t4_rdy", 32'(RDY), 32'h1);
    chk("t4_di_kept", 32'(DI), 32'hC3);
    tick();

    // 5: ack timeout after 63 REQ cycles, late ack ignored
    AB = 24'h012345;
    tick();
    for (int i = 0; i < 62; i++) tick();
    chk("t5_req_62", 32'(mem_req), 32'h1);
    chk("t5_err_62", 32'(bus_err), 32'h0);
    tick();
    chk("t5_req_drop", 32'(mem_req), 32'h0);
    chk("t5_err", 32'(bus_err), 32'h1);
    chk("t5_di_ff", 32'(DI), 32'hFF);
    chk("t5_rdy", 32'(RDY), 32'h1);
    AB = 24'h000300;
    mem_ack = 1'b1; mem_rdata = 8'h12;
    tick();
    mem_ack = 1'b0;
    chk("t5_late_di", 32'(DI), 32'hFF);
    chk("t5_late_err", 32'(bus_err), 32'h1);

    // 6: reset during REQ
    tick();
    chk("t6_req_pre", 32'(mem_req), 32'h1);
    RST_N = 1'b0;
    #1;
    chk("t6_req_async", 32'(mem_req), 32'h0);
    chk("t6_err_clr", 32'(bus_err), 32'h0);
    chk("t6_di_clr", 32'(DI), 32'h00);
    tick();
    RST_N = 1'b1;
    chk("t6_rdy0", 32'(RDY), 32'h0);
    tick();
    chk("t6_rdy1", 32'(RDY), 32'h1);
    chk("t6_noreq", 32'(mem_req), 32'h0);
    AB = 24'h000400;
    tick();
    chk("t6_req", 32'(mem_req), 32'h1);
    chk("t6_addr", 32'(mem_addr), 32'h000400);
    mem_ack = 1'b1; mem_rdata = 8'h9B;
    tick();
    mem_ack = 1'b0;
    chk("t6_di", 32'(DI), 32'h9B);
    chk("t6_done_rdy", 32'(RDY), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
